// File: rtl/mem_ctrl_if.sv
// Shared memory bus between a host and mem_ctrl: line address plus the two
// bidirectional buses, resolved from each side's data and output-enable pair.
interface mem_ctrl_if #(
    parameter int BUS_SIZE  = 16,
    parameter int ADDR_SIZE = 15
);
    logic [ADDR_SIZE-1:0] mem_address;

    logic [BUS_SIZE-1:0]  host_data;
    logic                 host_data_oe;
    logic [1:0]           host_cmd;
    logic                 host_cmd_oe;

    logic [BUS_SIZE-1:0]  ctrl_data;
    logic                 ctrl_data_oe;
    logic [1:0]           ctrl_cmd;
    logic                 ctrl_cmd_oe;

    wire  [BUS_SIZE-1:0]  mem_data;
    wire  [1:0]           mem_command;

    // The controller has priority; nobody driving leaves the bus floating
    assign mem_data    = ctrl_data_oe ? ctrl_data :
                         (host_data_oe ? host_data : {BUS_SIZE{1'bz}});
    assign mem_command = ctrl_cmd_oe ? ctrl_cmd :
                         (host_cmd_oe ? host_cmd : 2'bzz);

    modport master (
        output mem_address, host_data, host_data_oe, host_cmd, host_cmd_oe,
        input  mem_data, mem_command, ctrl_data_oe, ctrl_cmd_oe
    );

    modport slave (
        input  mem_address, mem_data, mem_command,
        output ctrl_data, ctrl_data_oe, ctrl_cmd, ctrl_cmd_oe
    );
endinterface

// File: rtl/mem_ctrl.sv
// Main-memory model with fixed-latency line reads/writes over a shared bus.
// Optional macro MEM_CTRL_STATS_EN adds read_count/write_count outputs.
module mem_ctrl #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int LINE_COUNT        = 2**15,
    parameter int MEM_LATENCY       = 100
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_CTRL_STATS_EN
    output logic [31:0] read_count,
    output logic [31:0] write_count,
`endif
    mem_ctrl_if.slave   bus
);
    localparam int LINE_BYTES = 2**CACHE_OFFSET_SIZE;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEATS      = LINE_W / BUS_SIZE;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int IDX_W      = $clog2(LINE_COUNT);
    localparam int CNT_W      = 10;
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WAIT       = 3'd2,
        RD_BURST   = 3'd3,
        WR_RESP    = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [IDX_W-1:0]    r_addr, w_addr_nxt;
    logic [LINE_W-1:0]   r_line, w_line_nxt;
    logic                r_is_wr, w_is_wr_nxt;
    logic [BUS_SIZE-1:0] r_data_out, w_data_nxt;
    logic                r_data_oe, w_data_oe_nxt;
    logic                r_cmd_oe, w_cmd_oe_nxt;
    logic                w_commit, w_rd_acc, w_wr_acc;

    // Untouched lines read back the power-up pattern, so only written lines need storing
    logic [LINE_W-1:0]     r_mem [LINE_COUNT];
    logic [LINE_COUNT-1:0] r_written = '0;

    logic [IDX_W-1:0]  w_idx;
    logic [LINE_W-1:0] w_rd_line;
    logic [BEAT_W-1:0] w_col_idx;
    logic              w_unused_addr;

    function automatic logic [LINE_W-1:0] init_line(input logic [IDX_W-1:0] idx);
        logic [LINE_W-1:0] v;
        logic [31:0]       b;
        v = '0;
        for (int o = 0; o < LINE_BYTES; o++) begin
            b = 32'(idx) * 32'(LINE_BYTES) + 32'(o);
            v[8*o +: 8] = b[7:0];
        end
        return v;
    endfunction

    assign w_idx         = bus.mem_address[IDX_W-1:0];
    assign w_unused_addr = ^bus.mem_address;
    assign w_rd_line     = r_written[w_idx] ? r_mem[w_idx] : init_line(w_idx);
    assign w_col_idx     = r_cnt[BEAT_W-1:0];

    assign bus.ctrl_data    = r_data_out;
    assign bus.ctrl_data_oe = r_data_oe;
    assign bus.ctrl_cmd     = CMD_RESP;
    assign bus.ctrl_cmd_oe  = r_cmd_oe;

    // Next-state and next-output decode; r_cnt counts edges since the request edge
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_beat_nxt    = r_beat;
        w_addr_nxt    = r_addr;
        w_line_nxt    = r_line;
        w_is_wr_nxt   = r_is_wr;
        w_data_nxt    = r_data_out;
        w_data_oe_nxt = 1'b0;
        w_cmd_oe_nxt  = 1'b0;
        w_commit      = 1'b0;
        w_rd_acc      = 1'b0;
        w_wr_acc      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_command == CMD_READ) begin
                    w_addr_nxt  = w_idx;
                    w_line_nxt  = w_rd_line;
                    w_cnt_nxt   = CNT_W'(1);
                    w_is_wr_nxt = 1'b0;
                    w_rd_acc    = 1'b1;
                    w_state_nxt = WAIT;
                end else if (bus.mem_command == CMD_WRITE) begin
                    w_addr_nxt                = w_idx;
                    w_line_nxt[BUS_SIZE-1:0]  = bus.mem_data;
                    w_cnt_nxt                 = CNT_W'(1);
                    w_is_wr_nxt               = 1'b1;
                    w_wr_acc                  = 1'b1;
                    w_state_nxt               = WR_COLLECT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR_COLLECT: begin
                w_line_nxt[BUS_SIZE*w_col_idx +: BUS_SIZE] = bus.mem_data;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_col_idx == LAST_BEAT) begin
                    w_commit = 1'b1;
                    // Minimum latency has the response due on the commit edge itself
                    if (LAST_WAIT == CNT_W'(BEATS - 1)) begin
                        w_state_nxt  = WR_RESP;
                        w_cmd_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_state_nxt = WR_COLLECT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_WAIT) begin
                    w_cmd_oe_nxt = 1'b1;
                    if (r_is_wr) begin
                        w_state_nxt = WR_RESP;
                    end else begin
                        w_state_nxt   = RD_BURST;
                        w_data_oe_nxt = 1'b1;
                        w_data_nxt    = r_line[BUS_SIZE-1:0];
                        w_beat_nxt    = BEAT_W'(1);
                    end
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RD_BURST: begin
                // r_beat wraps to zero once the last beat is on the bus
                if (r_beat == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cmd_oe_nxt  = 1'b1;
                    w_data_oe_nxt = 1'b1;
                    w_data_nxt    = r_line[BUS_SIZE*r_beat +: BUS_SIZE];
                    w_beat_nxt    = r_beat + BEAT_W'(1);
                end
            end
            WR_RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered bus drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_addr     <= '0;
            r_line     <= '0;
            r_is_wr    <= 1'b0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_cmd_oe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_beat     <= w_beat_nxt;
            r_addr     <= w_addr_nxt;
            r_line     <= w_line_nxt;
            r_is_wr    <= w_is_wr_nxt;
            r_data_out <= w_data_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_cmd_oe   <= w_cmd_oe_nxt;
        end
    end

    // Line storage: reset never touches it, an aborted collect never reaches it
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            r_mem[r_addr]     <= w_line_nxt;
            r_written[r_addr] <= 1'b1;
        end
    end

`ifdef MEM_CTRL_STATS_EN
    // Accepted-request counters
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count  <= 32'd0;
            write_count <= 32'd0;
        end else begin
            read_count  <= read_count + {31'd0, w_rd_acc};
            write_count <= write_count + {31'd0, w_wr_acc};
        end
    end
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requests push expected response beats with
// their due cycle; a negedge monitor pops and checks every response cycle.
module tb_mem_ctrl;
    localparam int BUS   = 16;
    localparam int LA_W  = 15;
    localparam int LAT   = 100;
    localparam int LINES = 256;
    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD = 2'd2;
    localparam logic [1:0] WR = 2'd3;

    typedef struct {
        int          at;
        logic [15:0] data;
        bit          has_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    mem_ctrl_if #(.BUS_SIZE(BUS), .ADDR_SIZE(LA_W)) bus();

`ifdef MEM_CTRL_STATS_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
`endif

    mem_ctrl #(
        .BUS_SIZE(BUS), .MEM_ADDR_SIZE(19), .CACHE_OFFSET_SIZE(4),
        .LINE_COUNT(LINES), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef MEM_CTRL_STATS_EN
        .read_count(read_count),
        .write_count(write_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response cycle must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ctrl_cmd_oe) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_response: got cyc=%0d cmd=%0d data=%h, want no response",
                             cyc, bus.mem_command, bus.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.at || bus.mem_command != RESP || bus.ctrl_data_oe != e.has_data ||
                        (e.has_data && bus.mem_data != e.data)) begin
                        bad++;
                        $display("FAIL response: got cyc=%0d cmd=%0d data_oe=%0d data=%h, want cyc=%0d cmd=1 data_oe=%0d data=%h",
                                 cyc, bus.mem_command, bus.ctrl_data_oe, bus.mem_data, e.at, e.has_data, e.data);
                    end
                end
            end else if (bus.ctrl_data_oe) begin
                total++;
                bad++;
                $display("FAIL stray_data: got data_oe=1 cmd_oe=0 at cyc=%0d, want data_oe=0", cyc);
            end
        end
    end

    task automatic issue_read(input logic [14:0] a, input logic [127:0] line, input int nbeats, output int t0);
        @(negedge clk);
        bus.mem_address = a;
        bus.host_cmd    = RD;
        bus.host_cmd_oe = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        bus.host_cmd_oe = 1'b0;
        bus.host_cmd    = NOP;
        for (int i = 0; i < nbeats; i++)
            exp_q.push_back('{at: t0 + LAT - 1 + i, data: line[16*i +: 16], has_data: 1'b1});
    endtask

    // Drives beats 0..nbeats-1; with expect_resp the single write response is scheduled
    task automatic issue_write(input logic [14:0] a, input logic [127:0] line, input int nbeats,
                               input bit expect_resp);
        int t0;
        @(negedge clk);
        bus.mem_address  = a;
        bus.host_cmd     = WR;
        bus.host_cmd_oe  = 1'b1;
        bus.host_data    = line[15:0];
        bus.host_data_oe = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        bus.host_cmd_oe = 1'b0;
        bus.host_cmd    = NOP;
        for (int i = 1; i < nbeats; i++) begin
            bus.host_data = line[16*i +: 16];
            @(posedge clk); #1;
        end
        bus.host_data_oe = 1'b0;
        if (expect_resp)
            exp_q.push_back('{at: t0 + LAT - 1, data: 16'h0000, has_data: 1'b0});
    endtask

    task automatic pulse_cmd(input logic [1:0] c);
        bus.host_cmd    = c;
        bus.host_cmd_oe = 1'b1;
        @(posedge clk); #1;
        bus.host_cmd_oe = 1'b0;
        bus.host_cmd    = NOP;
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_done(input int extra);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d responses still pending, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (extra + 2) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge: reset is sampled at the next edge, then both drivers must be off
    task automatic pulse_reset(input string name);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (bus.ctrl_cmd_oe || bus.ctrl_data_oe) begin
            bad++;
            $display("FAIL %s: got cmd_oe=%0d data_oe=%0d, want 0 0", name, bus.ctrl_cmd_oe, bus.ctrl_data_oe);
        end
    endtask

    initial begin
        int t0;
        reset            = 1'b1;
        bus.mem_address  = '0;
        bus.host_data    = '0;
        bus.host_data_oe = 1'b0;
        bus.host_cmd     = NOP;
        bus.host_cmd_oe  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (bus.ctrl_cmd_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_cmd_oe: got %b, want 0", bus.ctrl_cmd_oe);
        end
        total++;
        if (bus.ctrl_data_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_data_oe: got %b, want 0", bus.ctrl_data_oe);
        end

        issue_read(15'h0001, 128'h1F1E1D1C1B1A19181716151413121110, 8, t0);
        wait_done(0);

        issue_write(15'h0005, 128'hA007A006A005A004A003A002A001A000, 8, 1'b1);
        wait_done(0);
        issue_read(15'h0005, 128'hA007A006A005A004A003A002A001A000, 8, t0);
        wait_done(0);
        issue_read(15'h0105, 128'hA007A006A005A004A003A002A001A000, 8, t0);
        wait_done(0);

        issue_read(15'h7FFF, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 8, t0);
        wait_done(0);

        // Commands while busy: WRITE during WAIT, READ during the burst
        issue_read(15'h0002, 128'h2F2E2D2C2B2A29282726252423222120, 8, t0);
        wait_until(t0 + 10);
        pulse_cmd(WR);
        wait_until(t0 + 101);
        pulse_cmd(RD);
        wait_done(LAT + 20);

`ifdef MEM_CTRL_STATS_EN
        total++;
        if (read_count != 32'd5 || write_count != 32'd1) begin
            bad++;
            $display("FAIL stats_count: got rd=%0d wr=%0d, want rd=5 wr=1", read_count, write_count);
        end
`endif

        // Reset after beat 2 of a write: storage must keep the power-up line
        issue_write(15'h0003, 128'hB107B106B105B104B103B102B101B100, 3, 1'b0);
        pulse_reset("abort_write_bus_release");
`ifdef MEM_CTRL_STATS_EN
        total++;
        if (read_count != 32'd0 || write_count != 32'd0) begin
            bad++;
            $display("FAIL stats_reset: got rd=%0d wr=%0d, want 0 0", read_count, write_count);
        end
`endif
        issue_read(15'h0003, 128'h3F3E3D3C3B3A39383736353433323130, 8, t0);
        wait_done(0);

        // Reset after commit, during WAIT: the written line must survive
        issue_write(15'h0007, 128'hB007B006B005B004B003B002B001B000, 8, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        pulse_reset("reset_in_wait");
        issue_read(15'h0007, 128'hB007B006B005B004B003B002B001B000, 8, t0);
        wait_done(0);

        // Reset in the middle of a read burst: only three beats may appear
        issue_read(15'h0009, 128'h9F9E9D9C9B9A99989796959493929190, 3, t0);
        wait_until(t0 + 101);
        pulse_reset("reset_mid_burst");
        wait_done(LAT + 20);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter BUS_SIZE, 16, width of mem_data in bits; one beat carries 2 bytes.
REQ-002 Parameter MEM_ADDR_SIZE, 19, byte-address width of main memory.
REQ-003 Parameter CACHE_OFFSET_SIZE, 4, line-offset bits; a line is 16 bytes, 8 beats.
REQ-004 Parameter LINE_COUNT, 2**15, lines physically stored; legal values are powers of two up to 2**(MEM_ADDR_SIZE-CACHE_OFFSET_SIZE).
REQ-005 Parameter MEM_LATENCY, 100, cycles from request sample to first response edge; legal range 8..1023.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mem_address  input  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  line address, sampled only with a READ/WRITE command.
REQ-009 mem_data  inout  BUS_SIZE  beat data; driven by this block only during read response beats, else z.
REQ-010 mem_command  inout  2  encoding NOP=0, RESPONSE=1, READ=2, WRITE=3; driven by this block only while responding, else z.

Function
REQ-011 States SHALL be IDLE, WR_COLLECT, WAIT, RD_BURST, WR_RESP; all transitions on posedge clk.
REQ-012 IDLE: mem_command==READ at edge t0 -> latch line address, load latency counter, go WAIT (read).
REQ-013 IDLE: mem_command==WRITE at edge t0 -> latch address and beat 0 from mem_data, go WR_COLLECT.
REQ-014 WR_COLLECT SHALL sample beats 1..7 at edges t0+1..t0+7, beat i into bytes 2i (low) and 2i+1 (high), then go WAIT (write).
REQ-015 Write line SHALL be committed to storage at edge t0+7; a read issued afterwards returns the new data.
REQ-016 WAIT SHALL count until edge t0+MEM_LATENCY-1, then go RD_BURST (read) or WR_RESP (write).
REQ-017 RD_BURST: after edges t0+MEM_LATENCY-1 .. t0+MEM_LATENCY+6, drive mem_command=RESPONSE and beat i=bytes{2i+1,2i}, i=0..7, one beat per cycle, little-endian.
REQ-018 WR_RESP: drive mem_command=RESPONSE for exactly one cycle after edge t0+MEM_LATENCY-1, mem_data stays z.
REQ-019 After the last response cycle both inout buses SHALL return to z and state to IDLE; next request accepted from the following edge.
REQ-020 Commands other than READ/WRITE in IDLE, and any command while not IDLE, SHALL be ignored with no state change.
REQ-021 Addresses SHALL wrap modulo LINE_COUNT (upper address bits ignored).
REQ-022 Storage contents at time zero: byte k = k mod 256 (k = line*16+offset).
REQ-023 mem_data/mem_command z or x values in IDLE SHALL not trigger a request.

Reset
REQ-024 reset high at a posedge: state IDLE, counters 0, mem_data and mem_command z from that edge on.
REQ-025 Reset mid-operation SHALL abort the transaction; a WR_COLLECT in progress SHALL not modify storage; a write already committed (REQ-015) stays.
REQ-026 Reset SHALL not alter storage contents.

Configuration
REQ-027 Macro MEM_CTRL_STATS_EN defined: add outputs read_count and write_count, 32 bits each, reset to 0, incremented at the edge the request is accepted, wrapping at 2**32.
REQ-028 MEM_CTRL_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Read line 0x0001 after reset, LAT=100 -> RESPONSE beats 100..107 cycles after request, data 0x1110,0x1312,...,0x1F1E.
REQ-030 Write line 0x0005 beats 0xA000..0xA007 -> one RESPONSE cycle at t0+100; subsequent read returns 0xA000..0xA007.
REQ-031 Read address 0x7FFF with LINE_COUNT=256 -> data of line 0xFF (0xF1F0..0xFFFE).
REQ-032 READ asserted during RD_BURST of previous read -> ignored; no extra response, buses z after 8 beats.
REQ-033 reset at t0+3 of a write, then read same line -> original init data, buses z the cycle after reset.
REQ-034 With MEM_CTRL_STATS_EN: 3 reads, 2 writes -> read_count=3, write_count=2; reset -> both 0.
